// File: rtl/led_s2p_rx_pkg.sv
// Shared definitions for the LED shift-chain link: receiver FSM states, shift direction
// encodings and the default frame length, common to transmitter and receiver.
package led_s2p_rx_pkg;

    localparam int DEFAULT_DATA_BITS = 16;

    localparam bit DIR_MSB_FIRST = 1'b0;
    localparam bit DIR_LSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_FULL    = 2'd2,
        ST_OVERRUN = 2'd3
    } state_e;

    // The receiver state is a pure function of how many bits have arrived.
    function automatic state_e state_from_count(int unsigned count, int unsigned data_bits);
        if (count == 0)              return ST_IDLE;
        else if (count < data_bits)  return ST_RECV;
        else if (count == data_bits) return ST_FULL;
        else                         return ST_OVERRUN;
    endfunction

endpackage

// File: rtl/led_s2p_rx_if.sv
// LED shift-chain bundle: serial lines driven by the transmitter side, parallel
// frame and status returned by the receiver side.
interface led_s2p_rx_if
    import led_s2p_rx_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS
);
    logic                 sclk;
    logic                 sclrn;
    logic                 sin;
    logic                 EN;
    logic [DATA_BITS-1:0] PData;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output sclk, sclrn, sin, EN,
        input  PData, valid, frame_err, busy
    );

    modport slave (
        input  sclk, sclrn, sin, EN,
        output PData, valid, frame_err, busy
    );
endinterface

// File: rtl/led_s2p_rx_sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous input, plus a single-cycle rise pulse
// taken from the synchronized level.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic d_sync,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign d_sync = sync_q[SYNC_STAGES-1];
    assign rise   = d_sync & ~prev_q;
endmodule

// File: rtl/led_s2p_rx.sv
// LED shift-chain receiver: collects a serial frame, latches it on EN rise and
// reports frames whose bit count was not exactly DATA_BITS.
module led_s2p_rx
    import led_s2p_rx_pkg::*;
#(
    parameter int DATA_BITS       = DEFAULT_DATA_BITS,
    parameter int DATA_COUNT_BITS = 5,
    parameter bit DIR             = DIR_MSB_FIRST,
    parameter int SYNC_STAGES     = 2
) (
    input  logic         clk,
    input  logic         rst,
    led_s2p_rx_if.slave  bus
);
    localparam logic [DATA_COUNT_BITS-1:0] CNT_SAT = DATA_COUNT_BITS'(DATA_BITS + 1);

    logic sclk_rise, en_rise, sclrn_s, sin_s;
    logic unused_sclk_lvl, unused_en_lvl, unused_sclrn_rise, unused_sin_rise;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_async(bus.sclk), .d_sync(unused_sclk_lvl), .rise(sclk_rise));
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
        .clk(clk), .rst(rst), .d_async(bus.EN), .d_sync(unused_en_lvl), .rise(en_rise));
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclrn (
        .clk(clk), .rst(rst), .d_async(bus.sclrn), .d_sync(sclrn_s), .rise(unused_sclrn_rise));
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sin (
        .clk(clk), .rst(rst), .d_async(bus.sin), .d_sync(sin_s), .rise(unused_sin_rise));

    logic [DATA_BITS-1:0]       sr_q, sr_d, pdata_q, pdata_d;
    logic [DATA_COUNT_BITS-1:0] cnt_q, cnt_d;
    logic                       valid_q, valid_d, ferr_q, ferr_d;
    state_e                     state_q, state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            pdata_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            pdata_q <= pdata_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        pdata_d = pdata_q;
        valid_d = 1'b0;
        ferr_d  = ferr_q;

        if (!sclrn_s) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (sclk_rise) begin
            sr_d = (DIR == DIR_LSB_FIRST) ? {sin_s, sr_q[DATA_BITS-1:1]}
                                          : {sr_q[DATA_BITS-2:0], sin_s};
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end

        state_d = state_from_count(32'(cnt_d), DATA_BITS);

        // Latch sees the post-shift view, so a bit arriving with EN is part of the frame.
        if (en_rise) begin
            pdata_d = sr_d;
            valid_d = 1'b1;
            ferr_d  = (state_d != ST_FULL);
            cnt_d   = '0;
            state_d = ST_IDLE;
        end
    end

    assign bus.PData     = pdata_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_led_s2p_rx.sv
// Bench for led_s2p_rx: one serial stream feeds an MSB-first and an LSB-first receiver;
// a bit-level model pushes expected latches into per-receiver scoreboards.
module tb_led_s2p_rx;
    import led_s2p_rx_pkg::*;

    localparam int DB = 16;

    typedef struct {
        logic [DB-1:0] pdata;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sclk = 1'b0, sclrn = 1'b1, sin = 1'b0, en = 1'b0;

    int errors = 0;
    int checks = 0;

    exp_t q_msb[$];
    exp_t q_lsb[$];
    exp_t e_msb, e_lsb;

    logic [DB-1:0] m_msb = '0;
    logic [DB-1:0] m_lsb = '0;
    int            m_cnt = 0;

    always #5 clk = ~clk;

    led_s2p_rx_if #(.DATA_BITS(DB)) bus_msb ();
    led_s2p_rx_if #(.DATA_BITS(DB)) bus_lsb ();

    assign bus_msb.sclk  = sclk;
    assign bus_msb.sclrn = sclrn;
    assign bus_msb.sin   = sin;
    assign bus_msb.EN    = en;
    assign bus_lsb.sclk  = sclk;
    assign bus_lsb.sclrn = sclrn;
    assign bus_lsb.sin   = sin;
    assign bus_lsb.EN    = en;

    led_s2p_rx #(.DATA_BITS(DB), .DATA_COUNT_BITS(5), .DIR(DIR_MSB_FIRST), .SYNC_STAGES(2))
        dut_msb (.clk(clk), .rst(rst), .bus(bus_msb));
    led_s2p_rx #(.DATA_BITS(DB), .DATA_COUNT_BITS(5), .DIR(DIR_LSB_FIRST), .SYNC_STAGES(2))
        dut_lsb (.clk(clk), .rst(rst), .bus(bus_lsb));

    // Scoreboard monitors: every valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst && bus_msb.valid) begin
            checks++;
            if (q_msb.size() == 0) begin
                errors++;
                $display("FAIL msb_unexpected_valid: got valid=1 PData=%h, required no pulse", bus_msb.PData);
            end else begin
                e_msb = q_msb.pop_front();
                if (bus_msb.PData !== e_msb.pdata || bus_msb.frame_err !== e_msb.err) begin
                    errors++;
                    $display("FAIL msb_latch: got PData=%h err=%b, required PData=%h err=%b",
                             bus_msb.PData, bus_msb.frame_err, e_msb.pdata, e_msb.err);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst && bus_lsb.valid) begin
            checks++;
            if (q_lsb.size() == 0) begin
                errors++;
                $display("FAIL lsb_unexpected_valid: got valid=1 PData=%h, required no pulse", bus_lsb.PData);
            end else begin
                e_lsb = q_lsb.pop_front();
                if (bus_lsb.PData !== e_lsb.pdata || bus_lsb.frame_err !== e_lsb.err) begin
                    errors++;
                    $display("FAIL lsb_latch: got PData=%h err=%b, required PData=%h err=%b",
                             bus_lsb.PData, bus_lsb.frame_err, e_lsb.pdata, e_lsb.err);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_shift(input logic b);
        m_msb = {m_msb[DB-2:0], b};
        m_lsb = {b, m_lsb[DB-1:1]};
        if (m_cnt < DB + 1) m_cnt++;
    endtask

    task automatic model_latch();
        q_msb.push_back('{pdata: m_msb, err: (m_cnt != DB)});
        q_lsb.push_back('{pdata: m_lsb, err: (m_cnt != DB)});
        m_cnt = 0;
    endtask

    task automatic model_clear();
        m_msb = '0;
        m_lsb = '0;
        m_cnt = 0;
    endtask

    task automatic send_bit(input logic b);
        sin = b;
        tick(4);
        sclk = 1'b1;
        model_shift(b);
        tick(4);
        sclk = 1'b0;
    endtask

    // Sends the first n bits of w in transmit order (top bits when MSB first).
    task automatic send_word(input logic [DB-1:0] w, input int n, input bit lsb_first);
        for (int i = 0; i < n; i++)
            send_bit(lsb_first ? w[i] : w[DB-1-i]);
    endtask

    task automatic drain();
        int waited = 0;
        while ((q_msb.size() != 0 || q_lsb.size() != 0) && waited < 20) begin
            tick(1);
            waited++;
        end
        checks++;
        if (q_msb.size() != 0 || q_lsb.size() != 0) begin
            errors++;
            $display("FAIL sb_timeout: got %0d/%0d pending latches after 20 cycles, required 0",
                     q_msb.size(), q_lsb.size());
            q_msb.delete();
            q_lsb.delete();
        end
    endtask

    task automatic pulse_en();
        model_latch();
        en = 1'b1;
        tick(6);
        en = 1'b0;
        tick(4);
        drain();
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if ({bus_msb.PData, bus_msb.valid, bus_msb.frame_err, bus_msb.busy} !== '0) begin
            errors++;
            $display("FAIL reset_msb: got PData=%h v=%b err=%b busy=%b, required all 0",
                     bus_msb.PData, bus_msb.valid, bus_msb.frame_err, bus_msb.busy);
        end
        checks++;
        if ({bus_lsb.PData, bus_lsb.valid, bus_lsb.frame_err, bus_lsb.busy} !== '0) begin
            errors++;
            $display("FAIL reset_lsb: got PData=%h v=%b err=%b busy=%b, required all 0",
                     bus_lsb.PData, bus_lsb.valid, bus_lsb.frame_err, bus_lsb.busy);
        end
        rst = 1'b1;
        tick(4);
    endtask

    task automatic test_msb_frame();
        send_word(16'hA5C3, DB, 1'b0);
        checks++;
        if (bus_msb.busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_busy_high: got busy=%b, required 1", bus_msb.busy);
        end
        pulse_en();
        checks++;
        if ({bus_msb.PData, bus_msb.frame_err, bus_msb.busy} !== {16'hA5C3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL t1_frame: got PData=%h err=%b busy=%b, required a5c3/0/0",
                     bus_msb.PData, bus_msb.frame_err, bus_msb.busy);
        end
    endtask

    task automatic test_lsb_frame();
        logic [DB-1:0] words [3] = '{16'h0001, 16'h8000, 16'hFFFF};
        for (int i = 0; i < 3; i++) begin
            send_word(words[i], DB, 1'b1);
            pulse_en();
            checks++;
            if ({bus_lsb.PData, bus_lsb.frame_err} !== {words[i], 1'b0}) begin
                errors++;
                $display("FAIL t2_lsb_word%0d: got PData=%h err=%b, required %h/0",
                         i, bus_lsb.PData, bus_lsb.frame_err, words[i]);
            end
        end
    endtask

    task automatic test_short_frame();
        send_word(16'hFFF0, 12, 1'b0);
        pulse_en();
        checks++;
        if (bus_msb.frame_err !== 1'b1) begin
            errors++;
            $display("FAIL t3_short_err: got err=%b, required 1", bus_msb.frame_err);
        end
        send_word(16'h1234, DB, 1'b0);
        pulse_en();
        checks++;
        if ({bus_msb.PData, bus_msb.frame_err} !== {16'h1234, 1'b0}) begin
            errors++;
            $display("FAIL t3_recover: got PData=%h err=%b, required 1234/0",
                     bus_msb.PData, bus_msb.frame_err);
        end
        // Zero-bit frame: re-latches the retained shift register and flags it.
        pulse_en();
        checks++;
        if ({bus_msb.PData, bus_msb.frame_err} !== {16'h1234, 1'b1}) begin
            errors++;
            $display("FAIL t3_empty: got PData=%h err=%b, required 1234/1",
                     bus_msb.PData, bus_msb.frame_err);
        end
    endtask

    task automatic test_overrun();
        send_word(16'hFFFF, DB, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        checks++;
        if (dut_msb.state_q !== ST_OVERRUN || bus_msb.busy !== 1'b1) begin
            errors++;
            $display("FAIL t4_state: got state=%0d busy=%b, required %0d/1",
                     dut_msb.state_q, bus_msb.busy, ST_OVERRUN);
        end
        pulse_en();
        checks++;
        if ({bus_msb.PData, bus_msb.frame_err} !== {16'hFFFE, 1'b1}) begin
            errors++;
            $display("FAIL t4_overrun: got PData=%h err=%b, required fffe/1",
                     bus_msb.PData, bus_msb.frame_err);
        end
    endtask

    task automatic test_sclrn();
        send_word(16'h7700, 8, 1'b0);
        sclrn = 1'b0;
        model_clear();
        tick(4);
        sclrn = 1'b1;
        tick(4);
        send_word(16'h5A5A, DB, 1'b0);
        pulse_en();
        checks++;
        if ({bus_msb.PData, bus_msb.frame_err} !== {16'h5A5A, 1'b0}) begin
            errors++;
            $display("FAIL t5_after_clear: got PData=%h err=%b, required 5a5a/0",
                     bus_msb.PData, bus_msb.frame_err);
        end
        // EN while the serial register is held clear latches zero as a bad frame.
        send_word(16'hF800, 5, 1'b0);
        sclrn = 1'b0;
        model_clear();
        tick(4);
        pulse_en();
        sclrn = 1'b1;
        tick(4);
        checks++;
        if ({bus_msb.PData, bus_msb.frame_err} !== {16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL t5_en_in_clear: got PData=%h err=%b, required 0000/1",
                     bus_msb.PData, bus_msb.frame_err);
        end
        // Last bit's sclk rise and EN rise arrive together.
        send_word(16'h3C3D, DB - 1, 1'b0);
        sin = 1'b1;
        tick(4);
        sclk = 1'b1;
        en   = 1'b1;
        model_shift(1'b1);
        model_latch();
        tick(4);
        sclk = 1'b0;
        tick(2);
        en = 1'b0;
        tick(4);
        drain();
        checks++;
        if ({bus_msb.PData, bus_msb.frame_err} !== {16'h3C3D, 1'b0}) begin
            errors++;
            $display("FAIL t5_aligned: got PData=%h err=%b, required 3c3d/0",
                     bus_msb.PData, bus_msb.frame_err);
        end
    endtask

    task automatic test_reset_mid();
        send_word(16'hFF00, 8, 1'b0);
        sin = 1'b1;
        tick(4);
        sclk = 1'b1;
        tick(1);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus_msb.PData, bus_msb.valid, bus_msb.frame_err, bus_msb.busy} !== '0) begin
            errors++;
            $display("FAIL t6_async_msb: got PData=%h v=%b err=%b busy=%b, required all 0",
                     bus_msb.PData, bus_msb.valid, bus_msb.frame_err, bus_msb.busy);
        end
        checks++;
        if ({bus_lsb.PData, bus_lsb.valid, bus_lsb.frame_err, bus_lsb.busy} !== '0) begin
            errors++;
            $display("FAIL t6_async_lsb: got PData=%h v=%b err=%b busy=%b, required all 0",
                     bus_lsb.PData, bus_lsb.valid, bus_lsb.frame_err, bus_lsb.busy);
        end
        sclk = 1'b0;
        model_clear();
        q_msb.delete();
        q_lsb.delete();
        tick(2);
        rst = 1'b1;
        tick(4);
        send_word(16'hC0DE, DB, 1'b0);
        pulse_en();
        checks++;
        if ({bus_msb.PData, bus_msb.frame_err} !== {16'hC0DE, 1'b0}) begin
            errors++;
            $display("FAIL t6_after_reset: got PData=%h err=%b, required c0de/0",
                     bus_msb.PData, bus_msb.frame_err);
        end
    endtask

    initial begin
        test_reset();
        test_msb_frame();
        test_lsb_frame();
        test_short_frame();
        test_overrun();
        test_sclrn();
        test_reset_mid();
        tick(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
